// File: rtl/wb_writeback_stage.sv
// wb_writeback_stage: writeback stage that forms the final write value, buffers it in a
// small FIFO feeding the register file write port, and tracks pending writes for ID.
`default_nettype none

module wb_writeback_stage #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic            mem_regwrite,
  input  logic [4:0]      mem_rd,
  input  logic [1:0]      mem_wbsel,
  input  logic [2:0]      mem_funct3,
  input  logic [1:0]      mem_addr_lo,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] mem_load_data,
  input  logic [XLEN-1:0] mem_pc4,
  input  logic            rf_ready,
  output logic [4:0]      waddr,
  output logic [XLEN-1:0] wdata,
  output logic            wen,
  input  logic            id_issue,
  input  logic [4:0]      id_rd,
  input  logic            id_regwrite,
  output logic [31:0]     busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [4:0]      addr_q [DEPTH];
  logic [4:0]      addr_d [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] data_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            wen_q, wen_d;
  logic [31:0]     busy_q, busy_d;

  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_ext;
  logic [XLEN-1:0] wb_data;
  logic            full, pop, accept, push;

  always_comb begin
    ld_byte = mem_load_data[7:0];
    case (mem_addr_lo)
      2'd1:    ld_byte = mem_load_data[15:8];
      2'd2:    ld_byte = mem_load_data[23:16];
      2'd3:    ld_byte = mem_load_data[31:24];
      default: ld_byte = mem_load_data[7:0];
    endcase
    ld_half = mem_addr_lo[1] ? mem_load_data[31:16] : mem_load_data[15:0];
    case (mem_funct3)
      3'b000:  ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001:  ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_ext = mem_load_data;
    endcase
    case (mem_wbsel)
      2'b01:   wb_data = ld_ext;
      2'b10:   wb_data = mem_pc4;
      default: wb_data = mem_alu_result;
    endcase
  end

  // A full FIFO can still accept when its head is leaving this same cycle.
  assign full      = (count_q == FULL_C);
  assign pop       = wen_q && rf_ready;
  assign mem_ready = !full || pop;
  assign accept    = mem_valid && mem_ready;
  assign push      = accept && mem_regwrite && (mem_rd != 5'd0);

  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    busy_d   = busy_q;

    if (push) begin
      addr_d[wr_ptr_q] = mem_rd;
      data_d[wr_ptr_q] = wb_data;
      wr_ptr_d         = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Output registers preload the next head so waddr/wdata come straight from flops
    // and hold their last value once the FIFO drains.
    wen_d = (count_d != '0);
    if (wen_d) begin
      waddr_d = addr_d[rd_ptr_d];
      wdata_d = data_d[rd_ptr_d];
    end

    if (pop) begin
      busy_d[waddr_q] = 1'b0;
    end
    if (id_issue && id_regwrite && (id_rd != 5'd0)) begin
      busy_d[id_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wen_q    <= 1'b0;
      busy_q   <= '0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      wen_q    <= wen_d;
      busy_q   <= busy_d;
    end
  end

  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign wen   = wen_q;
  assign busy  = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_writeback_stage.sv
// tb_wb_writeback_stage: directed and randomized scoreboard bench for wb_writeback_stage.
`default_nettype none

module tb_wb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_ready, mem_regwrite;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wbsel, mem_addr_lo;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_alu_result, mem_load_data, mem_pc4;
  logic        rf_ready;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        wen;
  logic        id_issue, id_regwrite;
  logic [4:0]  id_rd;
  logic [31:0] busy;

  wb_writeback_stage #(.DEPTH(2), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_regwrite(mem_regwrite),
    .mem_rd(mem_rd), .mem_wbsel(mem_wbsel), .mem_funct3(mem_funct3),
    .mem_addr_lo(mem_addr_lo), .mem_alu_result(mem_alu_result),
    .mem_load_data(mem_load_data), .mem_pc4(mem_pc4), .rf_ready(rf_ready),
    .waddr(waddr), .wdata(wdata), .wen(wen),
    .id_issue(id_issue), .id_rd(id_rd), .id_regwrite(id_regwrite), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_busy = '0;
  int          tests = 0;
  int          fails = 0;
  logic        rnd_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: value the register file should receive, from plain arithmetic.
  function automatic logic [31:0] model(input logic [1:0] sel, input logic [2:0] f3,
                                        input logic [1:0] alo, input logic [31:0] alu,
                                        input logic [31:0] ld, input logic [31:0] pc4);
    longint unsigned b, h;
    b = (longint'(ld) >> (8 * alo)) % 256;
    h = (longint'(ld) >> (alo >= 2 ? 16 : 0)) % 65536;
    if (sel == 2'd2) return pc4;
    if (sel != 2'd1) return alu;
    case (f3)
      3'd0:    return (b >= 128) ? 32'(b + 64'hFFFF_FF00) : 32'(b);
      3'd4:    return 32'(b);
      3'd1:    return (h >= 32768) ? 32'(h + 64'hFFFF_0000) : 32'(h);
      3'd5:    return 32'(h);
      default: return ld;
    endcase
  endfunction

  // Monitor: checks wen/busy every cycle and compares each retired write with the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("busy", busy, exp_busy);
        check("wen_vs_pending", {31'd0, wen}, {31'd0, exp_q.size() != 0});
        if (wen && rf_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", {27'd0, waddr}, 32'd0);
          end else begin
            check("waddr", {27'd0, waddr}, {27'd0, exp_q[0].rd});
            check("wdata", wdata, exp_q[0].data);
            exp_busy[exp_q[0].rd] = 1'b0;
            void'(exp_q.pop_front());
          end
        end
        if (id_issue && id_regwrite && id_rd != 5'd0) exp_busy[id_rd] = 1'b1;
      end
    end
  end

  // Drives one MEM transaction (called at posedge+1), waits for the handshake, records the expectation.
  task automatic send(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                      input logic [2:0] f3, input logic [1:0] alo, input logic [31:0] alu,
                      input logic [31:0] ld, input logic [31:0] pc4, input logic [31:0] req);
    bit fired = 0;
    mem_valid = 1'b1; mem_regwrite = rw; mem_rd = rd; mem_wbsel = sel; mem_funct3 = f3;
    mem_addr_lo = alo; mem_alu_result = alu; mem_load_data = ld; mem_pc4 = pc4;
    for (int i = 0; i < 60 && !fired; i++) begin
      @(negedge clk);
      fired = mem_ready;
      @(posedge clk);
      if (fired && rw && rd != 5'd0) exp_q.push_back('{rd: rd, data: req});
      #1;
    end
    if (!fired) check("handshake_timeout", 32'd0, 32'd1);
    mem_valid = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd);
    id_issue = 1'b1; id_regwrite = 1'b1; id_rd = rd;
    @(posedge clk); #1;
    id_issue = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ld_pat;
    ld_pat = 32'h80FF_7F01;
    rst = 1'b1; mem_valid = 0; mem_regwrite = 0; mem_rd = 0; mem_wbsel = 0; mem_funct3 = 0;
    mem_addr_lo = 0; mem_alu_result = 0; mem_load_data = 0; mem_pc4 = 0;
    rf_ready = 1'b1; id_issue = 0; id_rd = 0; id_regwrite = 0;
    idle(2);
    rst = 1'b0;

    @(negedge clk);
    check("rst_wen", {31'd0, wen}, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_ready", {31'd0, mem_ready}, 32'd1);
    check("rst_waddr", {27'd0, waddr}, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    @(posedge clk); #1;

    // ALU write to x5 with a pending busy bit
    issue(5'd5);
    send(1, 5'd5, 2'b00, 3'd0, 2'd0, 32'h1234_5678, 32'd0, 32'd0, 32'h1234_5678);
    @(negedge clk);
    check("alu_wen", {31'd0, wen}, 32'd1);
    check("alu_waddr", {27'd0, waddr}, 32'd5);
    check("alu_wdata", wdata, 32'h1234_5678);
    idle(2);
    check("alu_busy5_clear", {31'd0, busy[5]}, 32'd0);

    // load extension and PC+4 / wbsel=11
    send(1, 5'd10, 2'b01, 3'b000, 2'd2, 32'd0, ld_pat, 32'd0, 32'hFFFF_FFFF);
    send(1, 5'd11, 2'b01, 3'b100, 2'd3, 32'd0, ld_pat, 32'd0, 32'h0000_0080);
    send(1, 5'd12, 2'b01, 3'b001, 2'd0, 32'd0, ld_pat, 32'd0, 32'h0000_7F01);
    send(1, 5'd13, 2'b01, 3'b101, 2'd2, 32'd0, ld_pat, 32'd0, 32'h0000_80FF);
    send(1, 5'd14, 2'b01, 3'b001, 2'd2, 32'd0, ld_pat, 32'd0, 32'hFFFF_80FF);
    send(1, 5'd15, 2'b01, 3'b010, 2'd0, 32'd0, ld_pat, 32'd0, 32'h80FF_7F01);
    send(1, 5'd16, 2'b10, 3'b000, 2'd0, 32'hAAAA_0000, ld_pat, 32'h0000_1004, 32'h0000_1004);
    send(1, 5'd17, 2'b11, 3'b000, 2'd0, 32'hCAFE_F00D, ld_pat, 32'h0000_1004, 32'hCAFE_F00D);
    idle(3);

    // backpressure: two fill the FIFO, the third waits for the first pop
    rf_ready = 1'b0;
    send(1, 5'd1, 2'b00, 3'd0, 2'd0, 32'h0000_0001, 32'd0, 32'd0, 32'h0000_0001);
    send(1, 5'd2, 2'b00, 3'd0, 2'd0, 32'h0000_0002, 32'd0, 32'd0, 32'h0000_0002);
    fork
      send(1, 5'd3, 2'b00, 3'd0, 2'd0, 32'h0000_0003, 32'd0, 32'd0, 32'h0000_0003);
      begin
        @(negedge clk);
        check("full_ready_low", {31'd0, mem_ready}, 32'd0);
        @(posedge clk); #1;
        rf_ready = 1'b1;
        @(negedge clk);
        check("full_pop_ready", {31'd0, mem_ready}, 32'd1);
      end
    join
    idle(4);

    // x0 and no-write instructions complete the handshake but never write
    send(1, 5'd0, 2'b00, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0);
    send(0, 5'd7, 2'b00, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0);
    idle(2);
    check("filter_wen", {31'd0, wen}, 32'd0);
    check("filter_busy7", {31'd0, busy[7]}, 32'd0);

    // issue x9 in the same cycle an older x9 write retires
    issue(5'd9);
    rf_ready = 1'b0;
    send(1, 5'd9, 2'b00, 3'd0, 2'd0, 32'h0000_0099, 32'd0, 32'd0, 32'h0000_0099);
    id_issue = 1'b1; id_regwrite = 1'b1; id_rd = 5'd9; rf_ready = 1'b1;
    @(posedge clk); #1;
    id_issue = 1'b0;
    check("collision_busy9", {31'd0, busy[9]}, 32'd1);
    idle(2);

    // reset while two writes are queued
    rf_ready = 1'b0;
    issue(5'd20);
    send(1, 5'd20, 2'b00, 3'd0, 2'd0, 32'h0000_0020, 32'd0, 32'd0, 32'h0000_0020);
    send(1, 5'd21, 2'b00, 3'd0, 2'd0, 32'h0000_0021, 32'd0, 32'd0, 32'h0000_0021);
    #2 rst = 1'b1;
    #1;
    check("midrst_wen", {31'd0, wen}, 32'd0);
    check("midrst_busy", busy, 32'd0);
    check("midrst_ready", {31'd0, mem_ready}, 32'd1);
    exp_q.delete();
    exp_busy = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    rf_ready = 1'b1;
    idle(2);

    // randomized traffic with random register-file stalls and ID issues
    rnd_on = 1'b1;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          logic [1:0]  sel, alo;
          logic [2:0]  f3;
          logic [31:0] alu, ld, pc4;
          logic [4:0]  rd;
          logic        rw;
          sel = 2'($urandom); alo = 2'($urandom); f3 = 3'($urandom);
          alu = $urandom; ld = $urandom; pc4 = $urandom;
          rd = 5'($urandom); rw = ($urandom_range(0, 7) != 0);
          send(rw, rd, sel, f3, alo, alu, ld, pc4, model(sel, f3, alo, alu, ld, pc4));
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk); #1;
          rf_ready    = ($urandom_range(0, 1) == 1);
          id_issue    = ($urandom_range(0, 3) == 0);
          id_rd       = 5'($urandom);
          id_regwrite = ($urandom_range(0, 1) == 1);
        end
      end
    join
    id_issue = 1'b0;
    rf_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
